// File: rtl/uart_baud_generator.sv
// ---------------------------------------------------------------------------
// uart_baud_generator
//
// Programmable UART timebase. Produces a 4-bit 16x-oversampling phase
// counter that advances 16 times per UART bit period. The rate comes from a
// fractional phase-accumulator divider, so any integer baud rate is exact on
// average from a fixed system clock and no hardware divider is needed.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   Baud_Rate  requested baud rate in bit/s (0..131071), quasi-static
//   tick       16x oversampling phase 0..15, wraps once per bit period
// ---------------------------------------------------------------------------
module uart_baud_generator #(
    parameter int unsigned CLK_FREQ = 150_000_000,
    parameter int unsigned ACC_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] Baud_Rate,
    output logic [3:0]  tick
);

    localparam logic [ACC_W-1:0] CLK_FREQ_W = ACC_W'(CLK_FREQ);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]       tick_q, tick_d;
    logic [16:0]      baud_q, baud_d;

    logic [ACC_W-1:0] step;
    logic [ACC_W-1:0] sum;

    // Step is 16*Baud_Rate. Because the largest step is below CLK_FREQ, the
    // accumulator can cross CLK_FREQ at most once per clock, so a single
    // compare-and-subtract is enough and tick never advances twice at once.
    assign step = ACC_W'({Baud_Rate, 4'b0000});
    assign sum  = acc_q + step;

    // A changed rate restarts the phase from zero without advancing, so the
    // consumer sees a clean bit period at the new rate. Rate 0 freezes.
    always_comb begin
        acc_d  = acc_q;
        tick_d = tick_q;
        baud_d = baud_q;
        if (Baud_Rate != baud_q) begin
            baud_d = Baud_Rate;
            acc_d  = '0;
            tick_d = 4'd0;
        end else if (Baud_Rate == 17'd0) begin
            acc_d  = acc_q;
            tick_d = tick_q;
        end else if (sum >= CLK_FREQ_W) begin
            acc_d  = sum - CLK_FREQ_W;
            tick_d = tick_q + 4'd1;
        end else begin
            acc_d  = sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            tick_q <= 4'd0;
            baud_q <= 17'd0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
            baud_q <= baud_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: tb/tb_uart_baud_generator.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_baud_generator
//
// Directed bench for the UART baud timebase at the default 150 MHz clock.
// Expected phase values and advance latencies are worked out by hand from
// the rate arithmetic (edges to the k-th advance = ceil(k*CLK_FREQ/step)).
// ---------------------------------------------------------------------------
module tb_uart_baud_generator;

   logic        clock;
   logic        reset;
   logic [16:0] baudRate;
   logic [3:0]  tick;

   int assertCount = 0;
   int failCount   = 0;
   int stepErrors  = 0;
   int advances;

   uart_baud_generator dut (
      .clk       (clock),
      .rst       (reset),
      .Baud_Rate (baudRate),
      .tick      (tick)
   );

   // 100 MHz-style bench clock; only edge counts matter to the design
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts, checks and reports one expectation
   task automatic checkOutput(input string tag, input int observed, input int expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Runs n rising edges, sampling 1 ns after each; counts +1 advances and
   // records any phase change that is not exactly +1 mod 16
   task automatic applyStimulus(input int n, output int adv);
      logic [3:0] prev;
      logic [3:0] nxt;
      adv = 0;
      for (int i = 0; i < n; i++) begin
         prev = tick;
         nxt  = prev + 4'd1;
         @(posedge clock);
         #1;
         if (tick !== prev) begin
            if (tick === nxt) adv++;
            else stepErrors++;
         end
      end
   endtask

   // Drives a new rate just after an edge and takes the restart edge
   task automatic newRate(input logic [16:0] rate);
      baudRate = rate;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset    = 1'b0;
      baudRate = 17'd0;
      #1 reset = 1'b1;
      #1;
      checkOutput("reset_async_tick", int'(tick), 0);
      @(posedge clock);
      @(posedge clock);
      #1;
      checkOutput("reset_held_tick", int'(tick), 0);
      reset = 1'b0;

      // Rate 0 from reset: baud_q already 0, so no restart and no motion
      applyStimulus(20, advances);
      checkOutput("zero_rate_adv", advances, 0);
      checkOutput("zero_rate_tick", int'(tick), 0);

      // 115200: step 1,843,200; first advance after 82 edges, wrap at 1303
      newRate(17'd115200);
      checkOutput("r115200_restart_tick", int'(tick), 0);
      applyStimulus(81, advances);
      checkOutput("r115200_pre_first_adv", advances, 0);
      applyStimulus(1, advances);
      checkOutput("r115200_first_adv_tick", int'(tick), 1);
      applyStimulus(1220, advances);
      checkOutput("r115200_adv_to_1302", advances, 14);
      checkOutput("r115200_tick_at_1302", int'(tick), 15);
      applyStimulus(1, advances);
      checkOutput("r115200_wrap_tick", int'(tick), 0);

      // 9600: step 153,600; 9th advance at ceil(9*976.5625)=8790 edges
      newRate(17'd9600);
      checkOutput("r9600_restart_tick", int'(tick), 0);
      applyStimulus(976, advances);
      checkOutput("r9600_pre_first_adv", advances, 0);
      applyStimulus(1, advances);
      checkOutput("r9600_first_adv_tick", int'(tick), 1);
      applyStimulus(7812, advances);
      checkOutput("r9600_tick_at_8789", int'(tick), 8);
      applyStimulus(1, advances);
      checkOutput("r9600_tick_at_8790", int'(tick), 9);

      // Switch to 115200 while tick==9: restart to 0, first advance at 82
      newRate(17'd115200);
      checkOutput("switch_restart_tick", int'(tick), 0);
      applyStimulus(81, advances);
      checkOutput("switch_pre_first_adv", advances, 0);
      applyStimulus(1, advances);
      checkOutput("switch_first_adv_tick", int'(tick), 1);

      // Rate 0 after running: one restart to 0, then hold
      applyStimulus(5, advances);
      newRate(17'd0);
      checkOutput("stop_restart_tick", int'(tick), 0);
      applyStimulus(50, advances);
      checkOutput("stop_hold_adv", advances, 0);
      checkOutput("stop_hold_tick", int'(tick), 0);

      // 57600: step 921,600; first advance at ceil(162.76)=163 edges
      newRate(17'd57600);
      applyStimulus(162, advances);
      checkOutput("r57600_pre_first_adv", advances, 0);
      applyStimulus(1, advances);
      checkOutput("r57600_first_adv_tick", int'(tick), 1);

      // Async reset mid-count at tick==12 (115200, 12th advance at edge 977)
      newRate(17'd115200);
      applyStimulus(977, advances);
      checkOutput("pre_reset_tick", int'(tick), 12);
      #3 reset = 1'b1;
      #1;
      checkOutput("async_reset_tick", int'(tick), 0);
      @(posedge clock);
      #1;
      baudRate = 17'd1200;
      reset    = 1'b0;

      // After release: one restart edge, then 7813 edges to the first
      // advance (19200 step, 7812.5 ratio); second advance at 15625 edges
      applyStimulus(7813, advances);
      checkOutput("r1200_pre_first_adv", advances, 0);
      checkOutput("r1200_pre_first_tick", int'(tick), 0);
      applyStimulus(1, advances);
      checkOutput("r1200_first_adv_tick", int'(tick), 1);
      applyStimulus(7811, advances);
      checkOutput("r1200_pre_second_adv", advances, 0);
      applyStimulus(1, advances);
      checkOutput("r1200_second_adv_tick", int'(tick), 2);

      // Maximum rate 131071: step 2,097,136; first advance at 72 edges,
      // floor(1072*2097136/150e6)=14 advances after 1072 edges
      newRate(17'd131071);
      checkOutput("rmax_restart_tick", int'(tick), 0);
      applyStimulus(71, advances);
      checkOutput("rmax_pre_first_adv", advances, 0);
      applyStimulus(1, advances);
      checkOutput("rmax_first_adv_tick", int'(tick), 1);
      applyStimulus(1000, advances);
      checkOutput("rmax_adv_1000", advances, 13);
      checkOutput("rmax_tick_at_1072", int'(tick), 14);

      // Every observed phase change must have been exactly +1 mod 16
      checkOutput("phase_step_errors", stepErrors, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
